// File: rtl/vai_pkg.sv
// Shared types and constants for the VAI register-slave arbiter.
package vai_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } vaiState_e;

  localparam int   DW_DEFAULT = 8;
  localparam logic CMD_READ   = 1'b0;
  localparam logic CMD_WRITE  = 1'b1;

  // Index of the set bit in a one-hot grant of up to four masters.
  function automatic logic [1:0] ohToIdx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vai_rr_pick.sv
// Round-robin winner selection: the first requester after the last-granted index wins.
module vai_rr_pick
  import vai_pkg::*;
#(
  parameter int CHANNELS = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [1:0]          ptr,
  output logic [CHANNELS-1:0] winner
);

  logic found;

  // Scan distances 1..CHANNELS from the pointer so the last owner ranks lowest.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!found && req[i] && (i == (int'(ptr) + k) % CHANNELS)) begin
          winner[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vai_arbiter.sv
// Arbiter sharing one VAI register slave between CHANNELS masters, one request/response frame at a time.
module vai_arbiter
  import vai_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DW       = DW_DEFAULT
) (
  input  logic                   Clk_i,
  input  logic                   Reset_i,
  input  logic [CHANNELS*DW-1:0] MstDin_i,
  input  logic [CHANNELS-1:0]    MstDinValid_i,
  input  logic [CHANNELS-1:0]    MstDinStart_i,
  input  logic [CHANNELS-1:0]    MstDinStop_i,
  output logic [CHANNELS-1:0]    MstDinAccept_o,
  output logic [CHANNELS*DW-1:0] MstDout_o,
  output logic [CHANNELS-1:0]    MstDoutValid_o,
  output logic [CHANNELS-1:0]    MstDoutStart_o,
  output logic [CHANNELS-1:0]    MstDoutStop_o,
  input  logic [CHANNELS-1:0]    MstDoutAccept_i,
  output logic [DW-1:0]          SlvDin_o,
  output logic                   SlvDinValid_o,
  output logic                   SlvDinStart_o,
  output logic                   SlvDinStop_o,
  input  logic                   SlvDinAccept_i,
  input  logic [DW-1:0]          SlvDout_i,
  input  logic                   SlvDoutValid_i,
  input  logic                   SlvDoutStart_i,
  input  logic                   SlvDoutStop_i,
  output logic                   SlvDoutAccept_o,
  output logic [CHANNELS-1:0]    Grant_o,
  output logic [CHANNELS-1:0]    Error_o
);

  vaiState_e           state, stateNext;
  logic [CHANNELS-1:0] grant, grantNext;
  logic [CHANNELS-1:0] startReq, pick;
  logic [1:0]          ptr, ptrNext;
  logic [3:0]          grantWide;

  assign startReq = MstDinValid_i & MstDinStart_i;
  assign Grant_o  = grant;

  vai_rr_pick #(.CHANNELS(CHANNELS)) uPick (
    .req   (startReq),
    .ptr   (ptr),
    .winner(pick)
  );

  // After reset the pointer sits on the last master so master 0 ranks first.
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= 2'(CHANNELS - 1);
    end else begin
      state <= stateNext;
      grant <= grantNext;
      ptr   <= ptrNext;
    end
  end

  always_comb begin
    grantWide                 = '0;
    grantWide[CHANNELS-1:0]   = grant;
  end

  always_comb begin
    stateNext       = state;
    grantNext       = grant;
    ptrNext         = ptr;
    MstDinAccept_o  = '0;
    Error_o         = '0;
    MstDout_o       = '0;
    MstDoutValid_o  = '0;
    MstDoutStart_o  = '0;
    MstDoutStop_o   = '0;
    SlvDin_o        = '0;
    SlvDinValid_o   = 1'b0;
    SlvDinStart_o   = 1'b0;
    SlvDinStop_o    = 1'b0;
    SlvDoutAccept_o = 1'b0;

    case (state)
      IDLE: begin
        // Stray beats without a start are swallowed and flagged; start beats wait for the grant.
        if (!Reset_i) begin
          MstDinAccept_o = MstDinValid_i & ~MstDinStart_i;
          Error_o        = MstDinValid_i & ~MstDinStart_i;
        end
        if (|startReq) begin
          stateNext = REQ;
          grantNext = pick;
        end
      end

      REQ: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (grant[i]) begin
            SlvDin_o          = MstDin_i[i*DW +: DW];
            SlvDinValid_o     = MstDinValid_i[i];
            SlvDinStart_o     = MstDinStart_i[i];
            SlvDinStop_o      = MstDinStop_i[i];
            MstDinAccept_o[i] = SlvDinAccept_i;
          end
        end
        if (SlvDinValid_o && SlvDinStop_o && SlvDinAccept_i) begin
          stateNext = RSP;
        end
      end

      RSP: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (grant[i]) begin
            MstDout_o[i*DW +: DW] = SlvDout_i;
            MstDoutValid_o[i]     = SlvDoutValid_i;
            MstDoutStart_o[i]     = SlvDoutStart_i;
            MstDoutStop_o[i]      = SlvDoutStop_i;
            SlvDoutAccept_o       = MstDoutAccept_i[i];
          end
        end
        if (SlvDoutValid_i && SlvDoutStop_i && SlvDoutAccept_o) begin
          stateNext = IDLE;
          grantNext = '0;
          ptrNext   = ohToIdx(grantWide);
        end
      end

      default: begin
        stateNext = IDLE;
        grantNext = '0;
      end
    endcase
  end

endmodule
